mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, meaning address width.
REQ-002 Parameter DW, default 32, meaning data width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0, req1  input  1 each  access request; requester 0 is instruction fetch, requester 1 is data.
REQ-006 we0, we1  input  1 each  write enable qualifying the request.
REQ-007 addr0, addr1  input  AW each  request address.
REQ-008 wdata0, wdata1  input  DW each  write data.
REQ-009 gnt0, gnt1  output  1 each  request accepted this cycle.
REQ-010 rvalid0, rvalid1  output  1 each  read data valid for that requester.
REQ-011 rdata0, rdata1  output  DW each  read data.
REQ-012 mem_w  output  1  memory write strobe.
REQ-013 mem_addr  output  AW  memory address.
REQ-014 mem_wdata  output  DW  memory write data.
REQ-015 mem_rdata  input  DW  combinational memory read data for mem_addr.

Function
REQ-016 At most one of gnt0/gnt1 SHALL be high in any cycle; gntN implies reqN.
REQ-017 gnt0/gnt1 SHALL be combinational from req0, req1, rst and the last-grant pointer; a transfer is accepted on the posedge where gntN=1.
REQ-018 With one request pending, that request SHALL be granted in the same cycle.
REQ-019 With both pending, the grant SHALL go to the requester not granted last (round-robin); the pointer updates on every accepted transfer.
REQ-020 mem_addr, mem_w and mem_wdata SHALL mirror the granted requester's addr, we and wdata; with no grant, mem_w=0, mem_addr=0 and mem_wdata=0.
REQ-021 An accepted read (we=0) SHALL capture mem_rdata at the accepting posedge and drive rvalidN=1 with rdataN for exactly the following cycle (latency 1).
REQ-022 An accepted write SHALL NOT produce rvalid.
REQ-023 Back-to-back accepted reads SHALL produce back-to-back rvalid pulses in grant order; sustained throughput is one transfer per cycle.
REQ-024 rdataN SHALL hold its last value while rvalidN=0.
REQ-025 The arbiter SHALL count consecutive cycles in which a requester is pending but not granted; the count SHALL saturate at 15 and clear on grant. Counter internal, observable in simulation.

Reset
REQ-026 While rst=1: gnt0=gnt1=0, mem_w=0, rvalid0=rvalid1=0, rdata0=rdata1=0, and the last-grant pointer selects requester 1, so requester 0 wins the first tie after reset.
REQ-027 A read accepted in the cycle before rst asserts SHALL NOT produce rvalid during reset; no rvalid is pending after rst deasserts.

Configuration
REQ-028 Macro MEM_ARBITER_FIXED_PRIO_EN: when defined, requester 0 SHALL always win ties and the pointer is unused; when undefined, REQ-019 round-robin applies.

Verification
REQ-029 req0=1 only, we0=0, addr0=5, mem_rdata=0xAA -> gnt0=1 same cycle, rvalid0=1 and rdata0=0xAA next cycle.
REQ-030 After reset, req0=req1=1 for 4 cycles -> grants 0,1,0,1; with MEM_ARBITER_FIXED_PRIO_EN -> 0,0,0,0 and starvation count of requester 1 = 4.
REQ-031 req1=1, we1=1, addr1=7, wdata1=0x1234 -> mem_w=1, mem_addr=7, mem_wdata=0x1234, no rvalid1.
REQ-032 Accepted read on requester 1 then rst=1 next cycle -> rvalid1=0, gnt0=gnt1=0 throughout reset.
REQ-033 No requests -> mem_w=0, mem_addr=0, gnt0=gnt1=0, rvalid0=rvalid1=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (0) and data (1) share one memory port.
// Define MEM_ARBITER_FIXED_PRIO_EN for fixed priority to requester 0; round-robin otherwise.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_w,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic [3:0]    starve0_q, starve0_d;
  logic [3:0]    starve1_q, starve1_d;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  always_comb begin
    gnt0 = ~rst & req0;
    gnt1 = ~rst & req1 & ~req0;
  end
`else
  // lastGnt_q names the requester granted most recently; the other one wins a tie.
  logic lastGnt_q, lastGnt_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        gnt0 = lastGnt_q;
        gnt1 = ~lastGnt_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
    lastGnt_d = lastGnt_q;
    if (gnt0) begin
      lastGnt_d = 1'b0;
    end else if (gnt1) begin
      lastGnt_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lastGnt_q <= 1'b1;
    end else begin
      lastGnt_q <= lastGnt_d;
    end
  end
`endif

  always_comb begin
    mem_w     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_w     = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_w     = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // Starvation counts clear whenever the requester is granted or stops asking.
  always_comb begin
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
    rdata0_d  = rvalid0_d ? mem_rdata : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_rdata : rdata1_q;
    starve0_d = 4'd0;
    starve1_d = 4'd0;
    if (req0 && !gnt0) begin
      starve0_d = (starve0_q == 4'd15) ? 4'd15 : starve0_q + 4'd1;
    end
    if (req1 && !gnt1) begin
      starve1_d = (starve1_q == 4'd15) ? 4'd15 : starve1_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      starve0_q <= 4'd0;
      starve1_q <= 4'd0;
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      starve0_q <= starve0_d;
      starve1_q <= starve1_d;
    end
  end

  // A read accepted just before reset must not show up while reset is held.
  assign rvalid0 = rvalid0_q & ~rst;
  assign rvalid1 = rvalid1_q & ~rst;
  assign rdata0  = rst ? '0 : rdata0_q;
  assign rdata1  = rst ? '0 : rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a cycle-level behavioural model of the arbitration rules.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_w;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int compareCount = 0;
  int missCount    = 0;

  // Model state: who was served last, pending read results, held read data, starvation counts
  int          lastWinner;
  bit          pendValid[2];
  logic [DW-1:0] heldData[2];
  int          starve[2];
  int          grantLog[$];

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compareCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check all outputs against the model, then advance the model.
  task automatic applyStimulus(input bit r, input bit q0, input bit w0, input logic [AW-1:0] a0,
                               input logic [DW-1:0] d0, input bit q1, input bit w1,
                               input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic [DW-1:0] mrd);
    int winner;
    bit qs[2], ws[2];
    logic [AW-1:0] as[2];
    logic [DW-1:0] ds[2];
    @(posedge clk);
    #1;
    rst = r; req0 = q0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = q1; we1 = w1; addr1 = a1; wdata1 = d1; mem_rdata = mrd;
    qs[0] = q0; qs[1] = q1; ws[0] = w0; ws[1] = w1;
    as[0] = a0; as[1] = a1; ds[0] = d0; ds[1] = d1;
    @(negedge clk);

    winner = -1;
    if (!r) begin
      if (q0 && q1) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
        winner = 0;
`else
        winner = 1 - lastWinner;
`endif
      end else if (q0) winner = 0;
      else if (q1) winner = 1;
    end

    checkOutput("gnt0", gnt0, winner == 0);
    checkOutput("gnt1", gnt1, winner == 1);
    checkOutput("mem_w", mem_w, (winner >= 0) ? ws[winner] : 1'b0);
    checkOutput("mem_addr", mem_addr, (winner >= 0) ? as[winner] : '0);
    checkOutput("mem_wdata", mem_wdata, (winner >= 0) ? ds[winner] : '0);
    checkOutput("rvalid0", rvalid0, !r && pendValid[0]);
    checkOutput("rvalid1", rvalid1, !r && pendValid[1]);
    checkOutput("rdata0", rdata0, r ? '0 : heldData[0]);
    checkOutput("rdata1", rdata1, r ? '0 : heldData[1]);
    if (!r) begin
      checkOutput("starve0", dut.starve0_q, starve[0]);
      checkOutput("starve1", dut.starve1_q, starve[1]);
    end
    grantLog.push_back(winner);

    if (r) begin
      lastWinner = 1;
      for (int i = 0; i < 2; i++) begin
        pendValid[i] = 0;
        heldData[i]  = '0;
        starve[i]    = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        pendValid[i] = (winner == i) && !ws[i];
        if (pendValid[i]) heldData[i] = mrd;
        if (qs[i] && winner != i) starve[i] = (starve[i] >= 15) ? 15 : starve[i] + 1;
        else starve[i] = 0;
      end
      if (winner >= 0) lastWinner = winner;
    end
  endtask

  task automatic idle(input bit r);
    applyStimulus(r, 0, 0, '0, '0, 0, 0, '0, '0, $urandom);
  endtask

  initial begin
    int g[$];
    rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
    lastWinner = 1;
    for (int i = 0; i < 2; i++) begin
      pendValid[i] = 0; heldData[i] = '0; starve[i] = 0;
    end

    idle(1); idle(1);
    idle(0);

    // Single read on requester 0 with known memory data
    applyStimulus(0, 1, 0, 32'd5, '0, 0, 0, '0, '0, 32'hAA);
    idle(0);
    checkOutput("dir_rdata0", rdata0, 32'hAA);

    // Tie sequence straight after reset
    idle(1);
    grantLog.delete();
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, 0, i, '0, 1, 0, 32'h100 + i, '0, $urandom);
    g = grantLog;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    checkOutput("dir_tie_seq", {g[0][1:0], g[1][1:0], g[2][1:0], g[3][1:0]}, 8'b00_00_00_00);
    idle(0);
    checkOutput("dir_starve1_was4", 64'(starve[1] == 0 && grantLog[$] == -1), 1);
`else
    checkOutput("dir_tie_seq", {g[0][1:0], g[1][1:0], g[2][1:0], g[3][1:0]}, 8'b00_01_00_01);
`endif

    // Write on requester 1: no rvalid must follow
    applyStimulus(0, 0, 0, '0, '0, 1, 1, 32'd7, 32'h1234, $urandom);
    idle(0);

    // Read accepted on requester 1, then reset the next cycle
    applyStimulus(0, 0, 0, '0, '0, 1, 0, 32'd9, '0, 32'h55);
    applyStimulus(1, 1, 0, '0, '0, 1, 0, 32'd3, '0, $urandom);
    applyStimulus(1, 1, 1, '0, '0, 1, 0, 32'd3, '0, $urandom);
    idle(0);
    idle(0);

    for (int n = 0; n < 2000; n++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                    $urandom, $urandom, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                    $urandom, $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", compareCount, missCount);
    $finish;
  end

endmodule
